// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the memory arbiter: line/address typedefs and
// the arbiter state encoding.
package lc3b_types;

   localparam int LC3B_ADDR_W = 16;
   localparam int LC3B_LINE_W = 128;

   typedef logic [LC3B_LINE_W-1:0] lc3b_line;
   typedef logic [LC3B_ADDR_W-1:0] lc3b_word;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_SERVE_I = 2'd1,
      ARB_SERVE_D = 2'd2
   } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts data grants taken while the instruction side waits; flags when the
// instruction side must be granted next. Used only with ARB_STARVE_GUARD_EN.
module arb_starve_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_read,
   input  logic d_grant,
   input  logic i_grant,
   output logic starve
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!i_read || i_grant)
         cnt <= '0;
      else if (d_grant && cnt != LIMIT)
         cnt <= cnt + 1'b1;
   end

   assign starve = i_read && (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory port between the LC-3b I-cache and D-cache.
// Data side wins by default; define ARB_STARVE_GUARD_EN to bound I-side wait.
module mem_arbiter
   import lc3b_types::*;
#(
   parameter int ADDR_W       = LC3B_ADDR_W,
   parameter int LINE_W       = LC3B_LINE_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);

   arb_state_t state, state_nxt;
   logic       d_req;
   logic       starve_force;

   assign d_req   = d_read | d_write;
   assign i_rdata = pmem_rdata;
   assign d_rdata = pmem_rdata;

`ifdef ARB_STARVE_GUARD_EN
   logic d_grant, i_grant;

   assign d_grant = (state == ARB_IDLE) && (state_nxt == ARB_SERVE_D);
   assign i_grant = (state == ARB_IDLE) && (state_nxt == ARB_SERVE_I);

   arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_read  (i_read),
      .d_grant (d_grant),
      .i_grant (i_grant),
      .starve  (starve_force)
   );
`else
   assign starve_force = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ARB_IDLE;
      else
         state <= state_nxt;
   end

   // Outputs decode from state, so an async reset zeroes them immediately.
   always_comb begin
      state_nxt    = state;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      i_resp       = 1'b0;
      d_resp       = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (d_req && !starve_force)
               state_nxt = ARB_SERVE_D;
            else if (i_read)
               state_nxt = ARB_SERVE_I;
         end
         ARB_SERVE_D: begin
            pmem_write   = d_write;
            pmem_read    = d_read & ~d_write;
            pmem_address = d_addr;
            pmem_wdata   = d_wdata;
            d_resp       = pmem_resp;
            if (pmem_resp || !d_req)
               state_nxt = ARB_IDLE;
         end
         ARB_SERVE_I: begin
            pmem_read    = i_read;
            pmem_address = i_addr;
            i_resp       = pmem_resp;
            if (pmem_resp || !i_read)
               state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   // Read+write together is a D-cache bug; the write wins in hardware.
   a_d_rw_excl: assert property (@(posedge clk) disable iff (!rst_n)
      !(state == ARB_SERVE_D && d_read && d_write));

   a_limit_nonzero: assert property (@(posedge clk) STARVE_LIMIT > 0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single I read, D priority,
// starvation guard (either build), mid-transaction reset, spurious resp, abort.
module tb_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_read, d_read, d_write, pmem_resp;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [LINE_W-1:0] d_wdata, pmem_rdata;
   logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
   logic              i_resp, d_resp, pmem_read, pmem_write;
   logic [ADDR_W-1:0] pmem_address;

   int n_vec = 0;
   int n_err = 0;
   logic watch = 1'b0;
   logic d_seen = 1'b0;

   localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
   localparam logic [LINE_W-1:0] LINE_WB = {8{16'hBEEF}};
   localparam logic [LINE_W-1:0] LINE_3C = {16{8'h3C}};

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_read       (i_read),
      .i_addr       (i_addr),
      .i_rdata      (i_rdata),
      .i_resp       (i_resp),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_resp       (d_resp),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   always @(posedge d_resp) if (watch) d_seen = 1'b1;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                      input logic [LINE_W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      pmem_resp = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
      #12;
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_write", pmem_write, 0);
      chk("rst_pmem_address", pmem_address, 0);
      chk("rst_pmem_wdata", pmem_wdata, 0);
      chk("rst_resps", {i_resp, d_resp}, 0);
      rst_n = 1'b1;

      // single I read
      cyc(); i_read = 1'b1; i_addr = 16'h1230; #1;
      chk("i_arb_cycle_read", pmem_read, 0);
      cyc();
      chk("i_read_strobe", pmem_read, 1);
      chk("i_addr", pmem_address, 16'h1230);
      chk("i_no_resp_yet", i_resp, 0);
      cyc();
      chk("i_addr_hold", pmem_address, 16'h1230);
      cyc(); pmem_resp = 1'b1; pmem_rdata = LINE_A5; #1;
      chk("i_resp", i_resp, 1);
      chk("i_rdata", i_rdata, LINE_A5);
      chk("i_resp_not_d", d_resp, 0);
      cyc(); pmem_resp = 1'b0; i_read = 1'b0; #1;
      chk("i_resp_one_cycle", i_resp, 0);
      chk("i_idle_read", pmem_read, 0);

      // simultaneous: D first, one turnaround, then I
      cyc(); i_read = 1'b1; i_addr = 16'h2220; d_write = 1'b1; d_addr = 16'h4000;
      d_wdata = LINE_WB; #1;
      chk("sim_idle_strobes", {pmem_read, pmem_write}, 0);
      cyc();
      chk("sim_d_strobes", {pmem_read, pmem_write}, 2'b01);
      chk("sim_d_addr", pmem_address, 16'h4000);
      chk("sim_d_wdata", pmem_wdata, LINE_WB);
      cyc(); pmem_resp = 1'b1; #1;
      chk("sim_d_resp", {i_resp, d_resp}, 2'b01);
      cyc(); pmem_resp = 1'b0; d_write = 1'b0; #1;
      chk("sim_turnaround", {pmem_read, pmem_write}, 0);
      cyc();
      chk("sim_i_strobes", {pmem_read, pmem_write}, 2'b10);
      chk("sim_i_addr", pmem_address, 16'h2220);
      cyc(); pmem_resp = 1'b1; #1;
      chk("sim_i_resp", {i_resp, d_resp}, 2'b10);
      cyc(); pmem_resp = 1'b0; i_read = 1'b0;

      // starvation: i_read held, D requesting back to back
      cyc(); i_read = 1'b1; d_read = 1'b1; d_addr = 16'h4000;
      for (int t = 0; t < 6; t++) begin
         logic [ADDR_W-1:0] exp_addr;
         exp_addr = 16'h4000;
`ifdef ARB_STARVE_GUARD_EN
         if (t == 4) exp_addr = 16'h2220;
`endif
         cyc(); pmem_resp = 1'b1; #1;
         chk($sformatf("starve_grant_%0d", t), pmem_address, exp_addr);
         chk($sformatf("starve_read_%0d", t), pmem_read, 1);
         cyc(); pmem_resp = 1'b0;
      end
      i_read = 1'b0; d_read = 1'b0;

      // reset during SERVE_D
      cyc(); d_write = 1'b1; d_addr = 16'h5550; d_wdata = LINE_3C;
      cyc();
      chk("rst_mid_pre", pmem_write, 1);
      watch = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_strobes", {pmem_read, pmem_write}, 0);
      chk("rst_mid_addr", pmem_address, 0);
      chk("rst_mid_wdata", pmem_wdata, 0);
      d_write = 1'b0;
      #2 rst_n = 1'b1;
      cyc();
      chk("rst_mid_after", {pmem_read, pmem_write}, 0);
      chk("rst_mid_no_d_resp", d_seen, 0);
      watch = 1'b0;

      // spurious pmem_resp in IDLE
      pmem_resp = 1'b1; #1;
      chk("spur_resps", {i_resp, d_resp}, 0);
      cyc(); pmem_resp = 1'b0; i_read = 1'b1; i_addr = 16'h3330; #1;
      chk("spur_still_idle", pmem_read, 0);
      cyc();
      chk("abort_pre_read", pmem_read, 1);
      chk("abort_pre_addr", pmem_address, 16'h3330);

      // I aborts; D granted after the return to IDLE
      i_read = 1'b0; d_read = 1'b1; d_addr = 16'h6660; #1;
      chk("abort_read_drop", pmem_read, 0);
      cyc();
      chk("abort_idle", {pmem_read, pmem_write}, 0);
      cyc();
      chk("abort_d_read", {pmem_read, pmem_write}, 2'b10);
      chk("abort_d_addr", pmem_address, 16'h6660);
      pmem_resp = 1'b1; pmem_rdata = LINE_3C; #1;
      chk("abort_d_resp", d_resp, 1);
      chk("abort_d_rdata", d_rdata, LINE_3C);
      cyc(); pmem_resp = 1'b0; d_read = 1'b0; #1;
      chk("final_idle", {pmem_read, pmem_write, i_resp, d_resp}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
